// File: rtl/belt_sort_sequencer.sv
// Belt motor and diverter sequencer for the waste sorter: stops the belt at
// the sensing station, fires the diverter for the classified bin, restarts.
module belt_sort_sequencer #(
   parameter int unsigned EJECT_CYC     = 25000000,
   parameter int unsigned CLASS_TIMEOUT = 100000000,
   parameter int unsigned CLEAR_TIMEOUT = 150000000,
   parameter int unsigned CNT_W         = 28
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       on_belt,
   input  logic       off_belt,
   input  logic       obj_detect,
   input  logic       class_valid,
   input  logic [1:0] class_code,
   output logic       belt_start,
   output logic       belt_stop,
   output logic [3:0] eject,
   output logic       fault,
   output logic       busy,
   output logic [7:0] sorted_cnt
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_RUN,
      S_CLASSIFY,
      S_EJECT,
      S_CLEAR,
      S_FAULT
   } state_t;

   localparam logic [CNT_W-1:0] EJECT_LAST = CNT_W'(EJECT_CYC - 1);
   localparam logic [CNT_W-1:0] CLASS_LAST = CNT_W'(CLASS_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] CLEAR_LAST = CNT_W'(CLEAR_TIMEOUT - 1);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] timer_q, timer_d;
   logic [3:0]       eject_q, eject_d;
   logic [7:0]       sorted_q, sorted_d;
   logic             start_q, start_d;
   logic             stop_q, stop_d;
   logic             fault_q, fault_d;
   logic             busy_q, busy_d;
   logic             obj_q, on_q;
   logic             need_edge_q, need_edge_d;
   logic             obj_rise, on_rise;

   assign obj_rise = obj_detect & ~obj_q;
   assign on_rise  = on_belt & ~on_q;

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      eject_d     = eject_q;
      sorted_d    = sorted_q;
      need_edge_d = need_edge_q;
      start_d     = 1'b0;
      stop_d      = 1'b0;

      // Operator stop preempts every transition outside IDLE.
      if (off_belt && state_q != S_IDLE) begin
         state_d = S_IDLE;
         stop_d  = 1'b1;
         eject_d = 4'b0000;
         timer_d = '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (on_belt && !off_belt && (!need_edge_q || on_rise)) begin
                  state_d     = S_RUN;
                  start_d     = 1'b1;
                  need_edge_d = 1'b0;
               end
            end
            S_RUN: begin
               if (obj_rise) begin
                  state_d = S_CLASSIFY;
                  stop_d  = 1'b1;
                  timer_d = '0;
               end
            end
            S_CLASSIFY: begin
               if (class_valid) begin
                  state_d = S_EJECT;
                  eject_d = 4'b0001 << class_code;
                  timer_d = '0;
               end else if (timer_q == CLASS_LAST) begin
                  state_d = S_FAULT;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
            S_EJECT: begin
               if (timer_q == EJECT_LAST) begin
                  state_d  = S_CLEAR;
                  eject_d  = 4'b0000;
                  sorted_d = sorted_q + 8'd1;
                  timer_d  = '0;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
            S_CLEAR: begin
               if (!obj_detect) begin
                  state_d = S_RUN;
                  start_d = 1'b1;
               end else if (timer_q == CLEAR_LAST) begin
                  state_d = S_FAULT;
               end else begin
                  timer_d = timer_q + 1'b1;
               end
            end
            S_FAULT: begin
               eject_d = 4'b0000;
               // Restart needs a fresh on_belt edge once back in IDLE.
               if (on_belt) begin
                  state_d     = S_IDLE;
                  need_edge_d = 1'b1;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end

      fault_d = (state_d == S_FAULT);
      busy_d  = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         timer_q     <= '0;
         eject_q     <= 4'b0000;
         sorted_q    <= 8'd0;
         start_q     <= 1'b0;
         stop_q      <= 1'b0;
         fault_q     <= 1'b0;
         busy_q      <= 1'b0;
         obj_q       <= 1'b0;
         on_q        <= 1'b0;
         need_edge_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         eject_q     <= eject_d;
         sorted_q    <= sorted_d;
         start_q     <= start_d;
         stop_q      <= stop_d;
         fault_q     <= fault_d;
         busy_q      <= busy_d;
         obj_q       <= obj_detect;
         on_q        <= on_belt;
         need_edge_q <= need_edge_d;
      end
   end

   assign belt_start = start_q;
   assign belt_stop  = stop_q;
   assign eject      = eject_q;
   assign fault      = fault_q;
   assign busy       = busy_q;
   assign sorted_cnt = sorted_q;

endmodule

// File: tb/tb_belt_sort_sequencer.sv
// Directed bench for belt_sort_sequencer with short eject/timeout constants.
module tb_belt_sort_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       on_belt, off_belt, obj_detect, class_valid;
   logic [1:0] class_code;
   logic       belt_start, belt_stop, fault, busy;
   logic [3:0] eject;
   logic [7:0] sorted_cnt;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] exp_cnt;

   belt_sort_sequencer #(
      .EJECT_CYC(10),
      .CLASS_TIMEOUT(20),
      .CLEAR_TIMEOUT(30),
      .CNT_W(28)
   ) dut (
      .clk(clk),
      .rst(rst),
      .on_belt(on_belt),
      .off_belt(off_belt),
      .obj_detect(obj_detect),
      .class_valid(class_valid),
      .class_code(class_code),
      .belt_start(belt_start),
      .belt_stop(belt_stop),
      .eject(eject),
      .fault(fault),
      .busy(busy),
      .sorted_cnt(sorted_cnt)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      on_belt = 0; off_belt = 0; obj_detect = 0;
      class_valid = 0; class_code = 2'd0;
      tick(); tick();
      chk("rst_start", belt_start, 0);
      chk("rst_stop", belt_stop, 0);
      chk("rst_eject", eject, 0);
      chk("rst_fault", fault, 0);
      chk("rst_busy", busy, 0);
      chk("rst_cnt", sorted_cnt, 0);
      rst = 1'b0;
      tick();

      // on and off together: off wins
      on_belt = 1; off_belt = 1;
      tick();
      chk("both_start", belt_start, 0);
      chk("both_busy", busy, 0);

      // 1: start
      off_belt = 0;
      tick();
      chk("t1_start", belt_start, 1);
      chk("t1_busy", busy, 1);
      on_belt = 0;
      tick();
      chk("t1_start_pulse", belt_start, 0);

      // 2: object, code 2 after 5 cycles
      obj_detect = 1;
      tick();
      chk("t2_stop", belt_stop, 1);
      repeat (4) tick();
      chk("t2_stop_pulse", belt_stop, 0);
      chk("t2_noeject", eject, 0);
      class_valid = 1; class_code = 2'd2;
      tick();
      chk("t2_eject_on", eject, 4'b0100);
      class_valid = 0; class_code = 2'd0;
      repeat (9) tick();
      chk("t2_eject_held", eject, 4'b0100);
      tick();
      chk("t2_eject_off", eject, 0);
      chk("t2_cnt", sorted_cnt, 1);
      tick();
      chk("t2_clear_wait", belt_start, 0);
      obj_detect = 0;
      tick();
      chk("t2_restart", belt_start, 1);
      tick();
      chk("t2_restart_pulse", belt_start, 0);

      // 3: classify timeout
      obj_detect = 1;
      tick();
      chk("t3_stop", belt_stop, 1);
      repeat (19) tick();
      chk("t3_prefault", fault, 0);
      tick();
      chk("t3_fault", fault, 1);
      chk("t3_eject", eject, 0);
      chk("t3_busy", busy, 1);
      repeat (3) tick();
      chk("t3_nostart", belt_start, 0);
      on_belt = 1;
      tick();
      chk("t3_ack_fault", fault, 0);
      chk("t3_ack_busy", busy, 0);
      tick();
      chk("t3_held_nostart", belt_start, 0);
      on_belt = 0;
      tick();
      on_belt = 1;
      tick();
      chk("t3_restart", belt_start, 1);
      on_belt = 0;
      tick();

      // 4: off_belt during eject
      obj_detect = 0;
      tick();
      obj_detect = 1;
      tick();
      chk("t4_stop", belt_stop, 1);
      class_valid = 1; class_code = 2'd1;
      tick();
      chk("t4_eject_on", eject, 4'b0010);
      class_valid = 0;
      tick(); tick();
      off_belt = 1;
      tick();
      chk("t4_eject_off", eject, 0);
      chk("t4_stop_off", belt_stop, 1);
      chk("t4_idle", busy, 0);
      chk("t4_cnt", sorted_cnt, 1);
      off_belt = 0;
      tick();
      chk("t4_stop_pulse", belt_stop, 0);

      // 5: 256 objects of class 3
      obj_detect = 0; on_belt = 1;
      tick();
      chk("t5_start", belt_start, 1);
      on_belt = 0;
      exp_cnt = 8'd1;
      for (int i = 0; i < 256; i++) begin
         obj_detect = 1;
         tick();
         class_valid = 1; class_code = 2'd3;
         tick();
         chk("t5_eject", eject, 4'b1000);
         class_valid = 0;
         repeat (10) tick();
         exp_cnt = exp_cnt + 8'd1;
         chk("t5_cnt", sorted_cnt, exp_cnt);
         if (i == 254) chk("t5_wrap", sorted_cnt, 0);
         obj_detect = 0;
         tick();
         chk("t5_restart", belt_start, 1);
      end

      // 6: async reset mid-classify
      obj_detect = 1;
      tick();
      chk("t6_stop", belt_stop, 1);
      tick(); tick();
      #2 rst = 1'b1;
      #1;
      chk("t6_busy", busy, 0);
      chk("t6_cnt", sorted_cnt, 0);
      chk("t6_eject", eject, 0);
      chk("t6_fault", fault, 0);
      tick();
      rst = 1'b0;
      class_valid = 1; class_code = 2'd0;
      tick();
      chk("t6_idle_ignore", eject, 0);
      class_valid = 0; on_belt = 1;
      tick();
      chk("t6_start", belt_start, 1);
      on_belt = 0; class_valid = 1;
      tick();
      chk("t6_run_ignore_eject", eject, 0);
      chk("t6_run_ignore_stop", belt_stop, 0);
      class_valid = 0; obj_detect = 0;
      tick();
      obj_detect = 1;
      tick();
      chk("t6_detect", belt_stop, 1);
      class_valid = 1; class_code = 2'd0;
      tick();
      chk("t6_eject", eject, 4'b0001);
      class_valid = 0;

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
